// File: rtl/nrisc_pkg.sv
// Shared definitions for the nRISC multi-cycle controller: opcodes, ALU
// control encodings, FSM state type and the bundle of registered control outputs.
package nrisc_pkg;

    localparam int ALU_W = 3;

    localparam logic [2:0] OP_R    = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_LW   = 3'b010;
    localparam logic [2:0] OP_SW   = 3'b011;
    localparam logic [2:0] OP_LFH  = 3'b100;
    localparam logic [2:0] OP_BEQ  = 3'b101;
    localparam logic [2:0] OP_J    = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
    localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b011;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b100;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_t;

    typedef struct packed {
        logic             ir_wr;
        logic             pc_inc;
        logic             pc_load;
        logic             pc_sel;
        logic             reg_wr;
        logic             alu_src;
        logic             reg_src;
        logic             lfh_sel;
        logic             mem_rd;
        logic             mem_wr;
        logic [ALU_W-1:0] alu_ctl;
        logic             busy;
        logic             halted;
    } ctl_t;

endpackage

// File: rtl/nrisc_mc_controller_if.sv
// Controller <-> datapath/memory signal bundle. The master modport is the
// controller; the slave modport is the datapath/memory side that feeds it.
interface nrisc_mc_controller_if
    import nrisc_pkg::*;
#(
    parameter int DATA_W = 8
);
    logic              run;
    logic [DATA_W-1:0] instr;
    logic              zero;
    logic              mem_ready;

    logic              ir_wr;
    logic              pc_inc;
    logic              pc_load;
    logic              pc_sel;
    logic              reg_wr;
    logic              alu_src;
    logic              reg_src;
    logic              lfh_sel;
    logic              mem_rd;
    logic              mem_wr;
    logic [ALU_W-1:0]  alu_ctl;
    logic              busy;
    logic              halted;
    logic              err;
    logic [7:0]        instr_count;

    modport master (
        input  run, instr, zero, mem_ready,
        output ir_wr, pc_inc, pc_load, pc_sel, reg_wr, alu_src, reg_src,
               lfh_sel, mem_rd, mem_wr, alu_ctl, busy, halted, err, instr_count
    );

    modport slave (
        output run, instr, zero, mem_ready,
        input  ir_wr, pc_inc, pc_load, pc_sel, reg_wr, alu_src, reg_src,
               lfh_sel, mem_rd, mem_wr, alu_ctl, busy, halted, err, instr_count
    );
endinterface

// File: rtl/nrisc_alu_decode.sv
// Combinational ALU decode: opcode + dist bit -> ALU operation and operand-B select.
module nrisc_alu_decode
    import nrisc_pkg::*;
(
    input  logic [2:0]       op_i,
    input  logic             dist_i,
    output logic [ALU_W-1:0] alu_ctl_o,
    output logic             alu_src_o
);

    always_comb begin
        alu_ctl_o = ALU_ADD;
        alu_src_o = 1'b0;
        case (op_i)
            OP_R:                          alu_ctl_o = dist_i ? ALU_SUB : ALU_ADD;
            OP_ADDI, OP_LW, OP_SW, OP_LFH: alu_src_o = 1'b1;
            OP_BEQ:                        alu_ctl_o = ALU_SUB;
            default:                       ;
        endcase
    end

endmodule

// File: rtl/nrisc_mc_controller.sv
// Multi-cycle nRISC control FSM with registered outputs and retired-instruction counter.
// Optional memory-access timeout is enabled by defining NRISC_MEM_TIMEOUT_EN.
module nrisc_mc_controller
    import nrisc_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = 15
) (
    input  logic                  clock,
    input  logic                  reset,
    nrisc_mc_controller_if.master bus
);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [7:0]        count_q, count_d;
    ctl_t              ctl_q, ctl_d;
    logic              retire;
    logic              timeout;
    logic [2:0]        op;
    logic [ALU_W-1:0]  dec_alu;
    logic              dec_src;
    logic              unused_ir_bits;

    assign op             = ir_q[DATA_W-1 -: 3];
    assign unused_ir_bits = ^ir_q[DATA_W-4:1];

    nrisc_alu_decode u_alu_dec (
        .op_i      (op),
        .dist_i    (ir_q[0]),
        .alu_ctl_o (dec_alu),
        .alu_src_o (dec_src)
    );

`ifdef NRISC_MEM_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q;

    assign wait_d  = (state_q == S_MEM && !bus.mem_ready) ? wait_q + WAIT_W'(1) : '0;
    assign timeout = (state_q == S_MEM) && !bus.mem_ready && (wait_q == WAIT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_q | timeout;
        end
    end

    assign bus.err = err_q;
`else
    // Without the timeout option MEM waits for mem_ready indefinitely.
    assign timeout = (TIMEOUT_CYC < 0);
    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        ir_d    = ir_q;
        count_d = count_q;
        retire  = 1'b0;
        ctl_d   = '0;

        case (state_q)
            S_IDLE:   if (bus.run) state_d = S_FETCH;
            S_FETCH: begin
                ir_d    = bus.instr;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (op == OP_HALT) begin
                    state_d = S_HALT;
                    retire  = 1'b1;
                end else begin
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                case (op)
                    OP_BEQ, OP_J: begin
                        state_d = S_FETCH;
                        retire  = 1'b1;
                    end
                    OP_LW, OP_SW, OP_LFH: state_d = S_MEM;
                    default:              state_d = S_WB;
                endcase
            end
            S_MEM: begin
                if (timeout) begin
                    state_d = S_HALT;
                end else if (bus.mem_ready) begin
                    state_d = (op == OP_SW) ? S_FETCH : S_WB;
                    retire  = (op == OP_SW);
                end
            end
            S_WB: begin
                state_d = S_FETCH;
                retire  = 1'b1;
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase

        if (retire) count_d = count_q + 8'd1;

        // Outputs are computed for the state being entered so that, once
        // registered, they line up with that state.
        case (state_d)
            S_FETCH: begin
                ctl_d.ir_wr  = 1'b1;
                ctl_d.pc_inc = 1'b1;
            end
            S_EXEC: begin
                ctl_d.alu_ctl = dec_alu;
                ctl_d.alu_src = dec_src;
                ctl_d.pc_load = (op == OP_BEQ) || (op == OP_J);
                ctl_d.pc_sel  = (op == OP_J);
            end
            S_MEM: begin
                ctl_d.alu_ctl = dec_alu;
                ctl_d.alu_src = dec_src;
                ctl_d.mem_rd  = (op != OP_SW);
                ctl_d.mem_wr  = (op == OP_SW);
                ctl_d.lfh_sel = (op == OP_LFH);
            end
            S_WB: begin
                ctl_d.alu_ctl = dec_alu;
                ctl_d.alu_src = dec_src;
                ctl_d.reg_wr  = 1'b1;
                ctl_d.reg_src = (op == OP_LW) || (op == OP_LFH);
            end
            default: ;
        endcase

        ctl_d.busy   = (state_d != S_IDLE) && (state_d != S_HALT);
        ctl_d.halted = (state_d == S_HALT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            ir_q    <= '0;
            count_q <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            count_q <= count_d;
            ctl_q   <= ctl_d;
        end
    end

    assign bus.ir_wr       = ctl_q.ir_wr;
    assign bus.pc_inc      = ctl_q.pc_inc;
    // zero is only valid during EXEC, so the branch is qualified in that cycle.
    assign bus.pc_load     = ctl_q.pc_load & (ctl_q.pc_sel | bus.zero);
    assign bus.pc_sel      = ctl_q.pc_sel;
    assign bus.reg_wr      = ctl_q.reg_wr;
    assign bus.alu_src     = ctl_q.alu_src;
    assign bus.reg_src     = ctl_q.reg_src;
    assign bus.lfh_sel     = ctl_q.lfh_sel;
    assign bus.mem_rd      = ctl_q.mem_rd;
    assign bus.mem_wr      = ctl_q.mem_wr;
    assign bus.alu_ctl     = ctl_q.alu_ctl;
    assign bus.busy        = ctl_q.busy;
    assign bus.halted      = ctl_q.halted;
    assign bus.instr_count = count_q;

endmodule

// File: tb/tb_nrisc_mc_controller.sv
// Scoreboard bench for nrisc_mc_controller: per-instruction expectations are
// queued when an instruction is issued and compared when it completes.
module tb_nrisc_mc_controller;

`ifdef NRISC_MEM_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO_CYC = 15;

    typedef struct {
        int         lat;
        int         pcl;
        int         pcs;
        int         rw;
        int         rwc;
        int         rsrc;
        int         mrd;
        int         mwr;
        int         lfh;
        int         alu;
        int         asrc;
        int         nb;
        int         err;
        logic [7:0] cnt;
        bit         halt;
    } exp_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    nrisc_mc_controller_if #(.DATA_W(8)) bus ();

    nrisc_mc_controller #(.DATA_W(8), .TIMEOUT_CYC(TMO_CYC)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [7:0] exp_count = 8'd0;
    exp_t       sbq[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] outs();
        return {bus.ir_wr, bus.pc_inc, bus.pc_load, bus.pc_sel, bus.reg_wr,
                bus.alu_src, bus.reg_src, bus.lfh_sel, bus.mem_rd, bus.mem_wr,
                bus.alu_ctl, bus.busy, bus.halted, bus.err, bus.instr_count};
    endfunction

    // Reference model of one instruction: w = mem_ready=0 cycles before the ready cycle.
    function automatic exp_t model(input logic [7:0] ins, input logic z, input int w);
        exp_t       e;
        logic [2:0] op;
        bit         memop;
        e = '{default: 0};
        e.alu  = -1;
        e.asrc = -1;
        op     = ins[7:5];
        memop  = (op == 3'd2) || (op == 3'd3) || (op == 3'd4);
        case (op)
            3'd0: begin e.lat = 4; e.alu = ins[0] ? 1 : 0; e.asrc = 0; e.rw = 1; end
            3'd1: begin e.lat = 4; e.alu = 0; e.asrc = 1; e.rw = 1; end
            3'd2: begin e.lat = 5 + w; e.alu = 0; e.asrc = 1; e.mrd = 1 + w; e.rw = 1; e.rsrc = 1; end
            3'd3: begin e.lat = 4 + w; e.alu = 0; e.asrc = 1; e.mwr = 1 + w; end
            3'd4: begin e.lat = 5 + w; e.alu = 0; e.asrc = 1; e.mrd = 1 + w; e.lfh = 1 + w; e.rw = 1; e.rsrc = 1; end
            3'd5: begin e.lat = 3; e.alu = 1; e.asrc = 0; e.pcl = int'(z); end
            3'd6: begin e.lat = 3; e.alu = 0; e.asrc = 0; e.pcl = 1; e.pcs = 1; end
            default: begin e.lat = 2; e.halt = 1'b1; end
        endcase
        if (TMO_EN && memop && w >= TMO_CYC) begin
            e.lat  = 3 + TMO_CYC;
            e.mrd  = (op != 3'd3) ? TMO_CYC : 0;
            e.mwr  = (op == 3'd3) ? TMO_CYC : 0;
            e.lfh  = (op == 3'd4) ? TMO_CYC : 0;
            e.rw   = 0;
            e.rsrc = 0;
            e.err  = 1;
            e.halt = 1'b1;
        end
        e.rwc = (e.rw != 0) ? e.lat : 0;
        return e;
    endfunction

    // Entered at the falling edge of a FETCH cycle; returns at the falling edge
    // of the next FETCH cycle or of the first HALT cycle.
    task automatic exec_instr(input logic [7:0] ins, input logic z, input int w, input bit rdy_out);
        exp_t  e, o;
        int    memc;
        bit    done;
        string t;
        t = $sformatf("%02h", ins);
        e = model(ins, z, w);
        if (e.err == 0) exp_count = exp_count + 8'd1;
        e.cnt = exp_count;
        sbq.push_back(e);

        o = '{default: 0};
        o.alu  = -1;
        o.asrc = -1;
        o.lat  = 1;
        memc   = 0;
        done   = 1'b0;
        bus.instr     = ins;
        bus.zero      = z;
        bus.mem_ready = rdy_out;
        for (int c = 0; c < 80 && !done; c++) begin
            @(negedge clock);
            if (c == 0) bus.instr = ~ins;
            if (bus.ir_wr || bus.halted) begin
                done = 1'b1;
            end else begin
                o.lat++;
                if (o.lat == 3) begin
                    o.alu  = int'(bus.alu_ctl);
                    o.asrc = int'(bus.alu_src);
                end
                o.pcl += int'(bus.pc_load);
                o.pcs |= int'(bus.pc_sel);
                if (bus.reg_wr) begin
                    o.rw++;
                    o.rwc  = o.lat;
                    o.rsrc |= int'(bus.reg_src);
                end
                o.mrd += int'(bus.mem_rd);
                o.mwr += int'(bus.mem_wr);
                o.lfh += int'(bus.lfh_sel);
                if (!bus.busy) o.nb++;
                if (bus.mem_rd || bus.mem_wr) begin
                    memc++;
                    bus.mem_ready = (memc > w);
                end else begin
                    bus.mem_ready = rdy_out;
                end
            end
        end
        chk({"done_", t}, int'(done), 1);
        o.err  = int'(bus.err);
        o.cnt  = bus.instr_count;
        o.halt = bus.halted;

        e = sbq.pop_front();
        chk({"lat_", t},    o.lat,  e.lat);
        chk({"pcload_", t}, o.pcl,  e.pcl);
        chk({"pcsel_", t},  o.pcs,  e.pcs);
        chk({"regwr_", t},  o.rw,   e.rw);
        chk({"regwrcyc_", t}, o.rwc, e.rwc);
        chk({"regsrc_", t}, o.rsrc, e.rsrc);
        chk({"memrd_", t},  o.mrd,  e.mrd);
        chk({"memwr_", t},  o.mwr,  e.mwr);
        chk({"lfhsel_", t}, o.lfh,  e.lfh);
        chk({"aluctl_", t}, o.alu,  e.alu);
        chk({"alusrc_", t}, o.asrc, e.asrc);
        chk({"notbusy_", t}, o.nb,  e.nb);
        chk({"err_", t},    o.err,  e.err);
        chk({"count_", t},  int'(o.cnt),  int'(e.cnt));
        chk({"halted_", t}, int'(o.halt), int'(e.halt));
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.instr     = 8'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("reset_outputs", int'(outs()), 0);
        reset = 1'b0;
        exp_count = 8'd0;
        sbq.delete();
        @(negedge clock);
    endtask

    task automatic start_run();
        int n;
        bus.run = 1'b1;
        n = 0;
        for (int c = 1; c <= 10 && n == 0; c++) begin
            @(negedge clock);
            if (bus.ir_wr) n = c;
        end
        chk("first_fetch_cycle", n, 1);
        bus.run = 1'b0;
    endtask

    task automatic reset_mid_mem();
        bit seen;
        bus.instr     = 8'h42;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 10 && !seen; c++) begin
            @(negedge clock);
            if (bus.mem_rd) seen = 1'b1;
        end
        chk("mid_mem_reached", int'(seen), 1);
        #2 reset = 1'b1;
        #1;
        chk("async_mem_rd_drop", int'(bus.mem_rd), 0);
        chk("async_reset_outputs", int'(outs()), 0);
        @(negedge clock);
        reset = 1'b0;
        exp_count = 8'd0;
        sbq.delete();
        @(negedge clock);
    endtask

    initial begin
        logic [23:0] hv;
        bus.run       = 1'b0;
        bus.instr     = 8'h00;
        bus.zero      = 1'b0;
        bus.mem_ready = 1'b0;

        do_reset();
        repeat (3) @(negedge clock);
        chk("idle_without_run", int'(bus.busy), 0);

        start_run();
        exec_instr(8'h00, 1'b0, 0, 1'b0);  // add
        exec_instr(8'h01, 1'b0, 0, 1'b0);  // sub
        exec_instr(8'h23, 1'b0, 0, 1'b1);  // addi, mem_ready high outside MEM
        exec_instr(8'hA5, 1'b1, 0, 1'b0);  // beq taken
        exec_instr(8'hA5, 1'b0, 0, 1'b0);  // beq not taken
        exec_instr(8'hC7, 1'b0, 0, 1'b0);  // j
        exec_instr(8'h42, 1'b0, 3, 1'b0);  // lw, 3 wait cycles
        exec_instr(8'h82, 1'b0, 0, 1'b1);  // lfh
        exec_instr(8'h61, 1'b0, 2, 1'b0);  // sw, 2 wait cycles
        exec_instr(8'h43, 1'b0, 1, 1'b1);  // lw
        exec_instr(8'h44, 1'b0, 20, 1'b0); // lw, long stall (timeout when enabled)

        do_reset();
        start_run();
        exec_instr(8'hC1, 1'b0, 0, 1'b0);
        reset_mid_mem();

        start_run();
        for (int i = 0; i < 256; i++) exec_instr(8'hC1, 1'b0, 0, 1'b0);
        chk("count_wrap", int'(bus.instr_count), 0);

        do_reset();
        start_run();
        exec_instr(8'h61, 1'b0, 1, 1'b0);
        exec_instr(8'hE0, 1'b0, 0, 1'b0);
        chk("halt_busy", int'(bus.busy), 0);
        hv = {10'b0, 3'b000, 1'b0, 1'b1, 1'b0, 8'd2};
        for (int i = 0; i < 6; i++) begin
            bus.run = ~bus.run;
            bus.mem_ready = bus.run;
            @(negedge clock);
            chk("halt_hold", int'(outs()), int'(hv));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
